// File: rtl/swerv_types.sv
// -----------------------------------------------------------------------------
// swerv_types: shared trace types.
//   trace_pkt_t : per-cycle retirement packet, three slots, from the core.
//   trace_rec_t : one compacted per-instruction trace record.
//   popcount3   : number of valid slots in a packet.
// -----------------------------------------------------------------------------
package swerv_types;

   typedef struct packed {
      logic [2:0]  trace_rv_i_valid_ip;
      logic [95:0] trace_rv_i_insn_ip;
      logic [95:0] trace_rv_i_address_ip;
      logic [2:0]  trace_rv_i_exception_ip;
      logic [4:0]  trace_rv_i_ecause_ip;
      logic [2:0]  trace_rv_i_interrupt_ip;
      logic [31:0] trace_rv_i_tval_ip;
   } trace_pkt_t;

   typedef struct packed {
      logic        ovf;
      logic        exception;
      logic        interrupt;
      logic [4:0]  ecause;
      logic [31:0] tval;
      logic [31:0] addr;
      logic [31:0] insn;
   } trace_rec_t;

   localparam int TRACE_SLOTS = 3;

   function automatic logic [1:0] popcount3(input logic [2:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
   endfunction

endpackage

// File: rtl/swerv_trace_compact.sv
// -----------------------------------------------------------------------------
// swerv_trace_compact: combinational slot compactor.
//   trace_pkt : retirement packet (in)
//   n         : number of valid slots, 0..3 (out)
//   rec0..2   : valid slots packed in ascending slot order; unused outputs 0,
//               ovf always 0 (the top level owns the overflow marker) (out)
// -----------------------------------------------------------------------------
module swerv_trace_compact
   import swerv_types::*;
(
   input  trace_pkt_t trace_pkt,
   output logic [1:0] n,
   output trace_rec_t rec0,
   output trace_rec_t rec1,
   output trace_rec_t rec2
);

   trace_rec_t slot_rec [TRACE_SLOTS];
   logic [1:0] idx;
   logic       trap;

   always_comb begin
      for (int k = 0; k < TRACE_SLOTS; k++) begin
         slot_rec[k]           = '0;
         slot_rec[k].insn      = trace_pkt.trace_rv_i_insn_ip[32*k +: 32];
         slot_rec[k].addr      = trace_pkt.trace_rv_i_address_ip[32*k +: 32];
         slot_rec[k].exception = trace_pkt.trace_rv_i_exception_ip[k];
         slot_rec[k].interrupt = trace_pkt.trace_rv_i_interrupt_ip[k];
      end
      // ecause/tval are shared across slots; only a trapping slot owns them.
      for (int k = 0; k < TRACE_SLOTS; k++) begin
         trap = trace_pkt.trace_rv_i_exception_ip[k] | trace_pkt.trace_rv_i_interrupt_ip[k];
         if (trap) begin
            slot_rec[k].ecause = trace_pkt.trace_rv_i_ecause_ip;
            slot_rec[k].tval   = trace_pkt.trace_rv_i_tval_ip;
         end
      end
   end

   always_comb begin
      rec0 = '0;
      rec1 = '0;
      rec2 = '0;
      idx  = 2'd0;
      for (int k = 0; k < TRACE_SLOTS; k++) begin
         if (trace_pkt.trace_rv_i_valid_ip[k]) begin
            case (idx)
               2'd0:    rec0 = slot_rec[k];
               2'd1:    rec1 = slot_rec[k];
               default: rec2 = slot_rec[k];
            endcase
            idx = idx + 2'd1;
         end
      end
   end

   assign n = popcount3(trace_pkt.trace_rv_i_valid_ip);

endmodule

// File: rtl/swerv_trace_serializer.sv
// -----------------------------------------------------------------------------
// swerv_trace_serializer: compacts retirement packets into a record FIFO and
// emits one record per cycle on a valid/ready trace port.
//   clk, rst         : clock, async active-high reset
//   trace_pkt        : retirement packet sampled every cycle
//   trace_enable     : when low, packets are ignored (FIFO still drains)
//   tr_valid/ready   : record handshake toward the trace sink
//   tr_insn .. tr_ovf: head record fields (0 while tr_valid is low)
//   drop_count       : saturating count of dropped packets
//   fifo_level       : registered number of FIFO entries
//   idle             : FIFO empty and no overflow marker pending
// -----------------------------------------------------------------------------
module swerv_trace_serializer
   import swerv_types::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  trace_pkt_t                 trace_pkt,
   input  logic                       trace_enable,
   output logic                       tr_valid,
   input  logic                       tr_ready,
   output logic [31:0]                tr_insn,
   output logic [31:0]                tr_addr,
   output logic                       tr_exception,
   output logic                       tr_interrupt,
   output logic [4:0]                 tr_ecause,
   output logic [31:0]                tr_tval,
   output logic                       tr_ovf,
   output logic [CNT_W-1:0]           drop_count,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level,
   output logic                       idle
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);

   trace_rec_t mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx1, wr_idx2;
   logic [LVL_W-1:0] level_q, level_d, free_slots, n_ext;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

   logic [1:0]  n;
   trace_rec_t  rec0, rec1, rec2, rec0_m, head;
   logic        pop, push, drop, fits;

   swerv_trace_compact u_compact (
      .trace_pkt (trace_pkt),
      .n         (n),
      .rec0      (rec0),
      .rec1      (rec1),
      .rec2      (rec2)
   );

   always_comb begin
      n_ext      = LVL_W'(n);
      pop        = (level_q != '0) && tr_ready;
      // Space is judged on the registered level; a same-cycle pop is not credited.
      free_slots = LVL_W'(DEPTH) - level_q;
      fits       = n_ext <= free_slots;
      push       = trace_enable && (n != 2'd0) && fits;
      drop       = trace_enable && (n != 2'd0) && !fits;

      rec0_m     = rec0;
      rec0_m.ovf = ovf_q;

      wr_idx1    = wr_ptr_q + PTR_W'(1);
      wr_idx2    = wr_ptr_q + PTR_W'(2);
      wr_ptr_d   = push ? wr_ptr_q + PTR_W'(n) : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d    = level_q + (push ? n_ext : '0) - (pop ? LVL_W'(1) : '0);

      ovf_d      = ovf_q;
      if (drop)      ovf_d = 1'b1;
      else if (push) ovf_d = 1'b0;

      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ovf_q      <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         ovf_q      <= ovf_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Record storage carries no reset; validity is tracked by the level alone.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= rec0_m;
         if (n >= 2'd2) mem_q[wr_idx1] <= rec1;
         if (n == 2'd3) mem_q[wr_idx2] <= rec2;
      end
   end

   // Head is masked so the port reads as zero while empty (incl. after reset).
   always_comb begin
      head = tr_valid ? mem_q[rd_ptr_q] : '0;
   end

   assign tr_valid     = (level_q != '0);
   assign tr_insn      = head.insn;
   assign tr_addr      = head.addr;
   assign tr_exception = head.exception;
   assign tr_interrupt = head.interrupt;
   assign tr_ecause    = head.ecause;
   assign tr_tval      = head.tval;
   assign tr_ovf       = head.ovf;
   assign drop_count   = drop_cnt_q;
   assign fifo_level   = level_q;
   assign idle         = (level_q == '0) && !ovf_q;

endmodule

// File: tb/tb_swerv_trace_serializer.sv
module tb_swerv_trace_serializer;
   import swerv_types::*;

   logic        clk = 1'b0;
   logic        rst, trace_enable, tr_ready;
   trace_pkt_t  trace_pkt;
   logic        tr_valid, tr_exception, tr_interrupt, tr_ovf, idle;
   logic [31:0] tr_insn, tr_addr, tr_tval;
   logic [4:0]  tr_ecause;
   logic [3:0]  drop_count;
   logic [3:0]  fifo_level;

   int pass_cnt = 0;
   int total_cnt = 0;

   swerv_trace_serializer #(.DEPTH(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .trace_pkt(trace_pkt), .trace_enable(trace_enable),
      .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_insn(tr_insn), .tr_addr(tr_addr),
      .tr_exception(tr_exception), .tr_interrupt(tr_interrupt), .tr_ecause(tr_ecause),
      .tr_tval(tr_tval), .tr_ovf(tr_ovf), .drop_count(drop_count),
      .fifo_level(fifo_level), .idle(idle)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] addr_of(int b, int k);
      return 32'h8000_0000 + 32'(b) * 256 + 32'(k) * 4;
   endfunction

   function automatic logic [31:0] insn_of(int b, int k);
      return 32'h1300_0000 + 32'(b) * 16 + 32'(k);
   endfunction

   function automatic trace_pkt_t mk_pkt(logic [2:0] v, logic [2:0] exc, logic [2:0] intr,
                                         logic [4:0] ec, logic [31:0] tv, int b);
      trace_pkt_t p;
      p = '0;
      p.trace_rv_i_valid_ip     = v;
      p.trace_rv_i_exception_ip = exc;
      p.trace_rv_i_interrupt_ip = intr;
      p.trace_rv_i_ecause_ip    = ec;
      p.trace_rv_i_tval_ip      = tv;
      for (int k = 0; k < 3; k++) begin
         p.trace_rv_i_insn_ip[32*k +: 32]    = insn_of(b, k);
         p.trace_rv_i_address_ip[32*k +: 32] = addr_of(b, k);
      end
      return p;
   endfunction

   task automatic do_reset();
      rst = 1'b1; trace_enable = 1'b1; tr_ready = 1'b0; trace_pkt = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; trace_enable = 1'b0; tr_ready = 1'b0; trace_pkt = '0;
      tick(); tick();
      total_cnt++; if (tr_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", tr_valid); else pass_cnt++;
      total_cnt++; if (idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", idle); else pass_cnt++;
      total_cnt++; if (fifo_level !== 4'd0) $display("FAIL reset_level: got %0d expected 0", fifo_level); else pass_cnt++;
      total_cnt++; if (drop_count !== 4'd0) $display("FAIL reset_drop: got %0d expected 0", drop_count); else pass_cnt++;
      total_cnt++; if ({tr_insn, tr_addr, tr_tval, tr_ecause, tr_ovf} !== '0) $display("FAIL reset_data: got %h expected 0", {tr_insn, tr_addr}); else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_single();
      trace_enable = 1'b1; tr_ready = 1'b1;
      trace_pkt = mk_pkt(3'b001, 3'b000, 3'b000, 5'h00, 32'h0, 10);
      tick();
      total_cnt++; if (tr_valid !== 1'b1) $display("FAIL single0_valid: got %b expected 1", tr_valid); else pass_cnt++;
      total_cnt++; if (tr_addr !== addr_of(10, 0)) $display("FAIL single0_addr: got %h expected %h", tr_addr, addr_of(10, 0)); else pass_cnt++;
      total_cnt++; if (tr_ovf !== 1'b0) $display("FAIL single0_ovf: got %b expected 0", tr_ovf); else pass_cnt++;
      trace_pkt = mk_pkt(3'b100, 3'b000, 3'b000, 5'h00, 32'h0, 11);
      tick();
      total_cnt++; if (tr_addr !== addr_of(11, 2)) $display("FAIL single2_addr: got %h expected %h", tr_addr, addr_of(11, 2)); else pass_cnt++;
      total_cnt++; if (tr_insn !== insn_of(11, 2)) $display("FAIL single2_insn: got %h expected %h", tr_insn, insn_of(11, 2)); else pass_cnt++;
      total_cnt++; if (fifo_level !== 4'd1) $display("FAIL single2_level: got %0d expected 1", fifo_level); else pass_cnt++;
      trace_pkt = '0;
      tick();
      total_cnt++; if (fifo_level !== 4'd0) $display("FAIL single_drain_level: got %0d expected 0", fifo_level); else pass_cnt++;
      total_cnt++; if (idle !== 1'b1) $display("FAIL single_drain_idle: got %b expected 1", idle); else pass_cnt++;
   endtask

   task automatic test_trap();
      tr_ready = 1'b0;
      trace_pkt = mk_pkt(3'b101, 3'b100, 3'b000, 5'h02, 32'hDEAD_BEEF, 20);
      tick();
      trace_pkt = '0;
      total_cnt++; if (fifo_level !== 4'd2) $display("FAIL trap_level: got %0d expected 2", fifo_level); else pass_cnt++;
      total_cnt++; if (tr_addr !== addr_of(20, 0)) $display("FAIL trap_s0_addr: got %h expected %h", tr_addr, addr_of(20, 0)); else pass_cnt++;
      total_cnt++; if ({tr_exception, tr_ecause, tr_tval} !== 38'h0) $display("FAIL trap_s0_cause: got %b %h %h expected 0 00 00000000", tr_exception, tr_ecause, tr_tval); else pass_cnt++;
      tr_ready = 1'b1;
      tick();
      total_cnt++; if (tr_addr !== addr_of(20, 2)) $display("FAIL trap_s2_addr: got %h expected %h", tr_addr, addr_of(20, 2)); else pass_cnt++;
      total_cnt++; if (tr_exception !== 1'b1 || tr_interrupt !== 1'b0) $display("FAIL trap_s2_flags: got %b%b expected 10", tr_exception, tr_interrupt); else pass_cnt++;
      total_cnt++; if (tr_ecause !== 5'h02) $display("FAIL trap_s2_ecause: got %h expected 02", tr_ecause); else pass_cnt++;
      total_cnt++; if (tr_tval !== 32'hDEAD_BEEF) $display("FAIL trap_s2_tval: got %h expected deadbeef", tr_tval); else pass_cnt++;
      tick();
      total_cnt++; if (fifo_level !== 4'd0) $display("FAIL trap_drain: got %0d expected 0", fifo_level); else pass_cnt++;
   endtask

   task automatic test_overflow();
      int         eb [6] = '{1, 2, 2, 2, 4, 5};
      int         ek [6] = '{2, 0, 1, 2, 0, 0};
      logic [5:0] eo = 6'b010000;
      do_reset();
      trace_pkt = mk_pkt(3'b111, 3'b000, 3'b000, 5'h0, 32'h0, 1); tick();
      trace_pkt = mk_pkt(3'b111, 3'b000, 3'b000, 5'h0, 32'h0, 2); tick();
      total_cnt++; if (fifo_level !== 4'd6) $display("FAIL ovf_fill_level: got %0d expected 6", fifo_level); else pass_cnt++;
      trace_pkt = mk_pkt(3'b111, 3'b000, 3'b000, 5'h0, 32'h0, 3); tick();
      total_cnt++; if (drop_count !== 4'd1) $display("FAIL ovf_drop_count: got %0d expected 1", drop_count); else pass_cnt++;
      total_cnt++; if (fifo_level !== 4'd6) $display("FAIL ovf_drop_level: got %0d expected 6", fifo_level); else pass_cnt++;
      total_cnt++; if (idle !== 1'b0) $display("FAIL ovf_idle: got %b expected 0", idle); else pass_cnt++;
      trace_pkt = mk_pkt(3'b001, 3'b000, 3'b000, 5'h0, 32'h0, 4); tick();
      total_cnt++; if (fifo_level !== 4'd7) $display("FAIL ovf_accept_level: got %0d expected 7", fifo_level); else pass_cnt++;
      // Level 7 with a concurrent pop: one slot fits, two slots do not.
      tr_ready = 1'b1;
      trace_pkt = mk_pkt(3'b001, 3'b000, 3'b000, 5'h0, 32'h0, 5); tick();
      total_cnt++; if (fifo_level !== 4'd7 || drop_count !== 4'd1) $display("FAIL full_1slot: got level %0d drops %0d expected 7 1", fifo_level, drop_count); else pass_cnt++;
      trace_pkt = mk_pkt(3'b011, 3'b000, 3'b000, 5'h0, 32'h0, 6); tick();
      total_cnt++; if (fifo_level !== 4'd6 || drop_count !== 4'd2) $display("FAIL full_2slot: got level %0d drops %0d expected 6 2", fifo_level, drop_count); else pass_cnt++;
      trace_pkt = '0;
      for (int i = 0; i < 6; i++) begin
         total_cnt++; if (tr_addr !== addr_of(eb[i], ek[i])) $display("FAIL ovf_drain_addr%0d: got %h expected %h", i, tr_addr, addr_of(eb[i], ek[i])); else pass_cnt++;
         total_cnt++; if (tr_ovf !== eo[i]) $display("FAIL ovf_drain_flag%0d: got %b expected %b", i, tr_ovf, eo[i]); else pass_cnt++;
         tick();
      end
      total_cnt++; if (tr_valid !== 1'b0 || idle !== 1'b0) $display("FAIL ovf_pending_idle: got valid %b idle %b expected 0 0", tr_valid, idle); else pass_cnt++;
      trace_pkt = mk_pkt(3'b001, 3'b000, 3'b000, 5'h0, 32'h0, 7); tick();
      trace_pkt = '0;
      total_cnt++; if (tr_ovf !== 1'b1 || tr_addr !== addr_of(7, 0)) $display("FAIL ovf_marker2: got %b %h expected 1 %h", tr_ovf, tr_addr, addr_of(7, 0)); else pass_cnt++;
      tick();
      total_cnt++; if (idle !== 1'b1) $display("FAIL ovf_final_idle: got %b expected 1", idle); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      trace_rec_t  sb [$];
      trace_rec_t  r;
      logic        ovf_m;
      logic [3:0]  dc_m;
      logic [2:0]  v;
      logic        rdy, en, held, pop;
      logic [31:0] prev_addr, prev_insn;
      trace_pkt_t  p;
      int          n, sz;
      do_reset();
      ovf_m = 1'b0; dc_m = 4'd0;
      for (int c = 0; c < 100; c++) begin
         if (c < 80) begin
            v = 3'($urandom_range(0, 7)); rdy = 1'($urandom_range(0, 1)); en = ($urandom_range(0, 7) != 0);
         end else begin
            v = 3'b000; rdy = 1'b1; en = 1'b1;
         end
         p = mk_pkt(v, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 5'h0B, $urandom, 100 + c);
         trace_pkt = p; tr_ready = rdy; trace_enable = en;
         held = tr_valid && !rdy;
         prev_addr = tr_addr; prev_insn = tr_insn;
         n = $countones(v); sz = sb.size();
         pop = (sz > 0) && rdy;
         tick();
         if (pop) void'(sb.pop_front());
         if (en && n > 0) begin
            if (n <= 8 - sz) begin
               for (int k = 0; k < 3; k++) begin
                  if (v[k]) begin
                     r = '0;
                     r.insn = insn_of(100 + c, k); r.addr = addr_of(100 + c, k);
                     r.exception = p.trace_rv_i_exception_ip[k]; r.interrupt = p.trace_rv_i_interrupt_ip[k];
                     if (r.exception || r.interrupt) begin r.ecause = 5'h0B; r.tval = p.trace_rv_i_tval_ip; end
                     r.ovf = ovf_m; ovf_m = 1'b0;
                     sb.push_back(r);
                  end
               end
            end else begin
               ovf_m = 1'b1;
               if (dc_m != 4'hF) dc_m = dc_m + 4'd1;
            end
         end
         total_cnt++; if (fifo_level !== 4'(sb.size())) $display("FAIL b2b_level c%0d: got %0d expected %0d", c, fifo_level, sb.size()); else pass_cnt++;
         total_cnt++; if (drop_count !== dc_m) $display("FAIL b2b_drops c%0d: got %0d expected %0d", c, drop_count, dc_m); else pass_cnt++;
         if (sb.size() > 0) begin
            r = sb[0];
            total_cnt++;
            if ({tr_valid, tr_ovf, tr_exception, tr_interrupt, tr_ecause, tr_tval, tr_addr, tr_insn} !== {1'b1, r})
               $display("FAIL b2b_head c%0d: got %b %h %h expected %h %h", c, tr_valid, tr_addr, tr_insn, r.addr, r.insn);
            else pass_cnt++;
         end
         if (held) begin
            total_cnt++; if (tr_addr !== prev_addr || tr_insn !== prev_insn) $display("FAIL b2b_hold c%0d: got %h expected %h", c, tr_addr, prev_addr); else pass_cnt++;
         end
      end
      total_cnt++; if (tr_valid !== 1'b0) $display("FAIL b2b_empty: got %b expected 0", tr_valid); else pass_cnt++;
   endtask

   task automatic test_saturation();
      do_reset();
      trace_pkt = mk_pkt(3'b111, 3'b000, 3'b000, 5'h0, 32'h0, 30); tick();
      trace_pkt = mk_pkt(3'b111, 3'b000, 3'b000, 5'h0, 32'h0, 31); tick();
      trace_pkt = mk_pkt(3'b011, 3'b000, 3'b000, 5'h0, 32'h0, 32); tick();
      total_cnt++; if (fifo_level !== 4'd8) $display("FAIL sat_full: got %0d expected 8", fifo_level); else pass_cnt++;
      trace_pkt = mk_pkt(3'b001, 3'b000, 3'b000, 5'h0, 32'h0, 33);
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) begin
            total_cnt++; if (drop_count !== 4'd14) $display("FAIL sat_14: got %0d expected 14", drop_count); else pass_cnt++;
         end
      end
      trace_pkt = '0;
      total_cnt++; if (drop_count !== 4'd15) $display("FAIL sat_hold: got %0d expected 15", drop_count); else pass_cnt++;
      total_cnt++; if (fifo_level !== 4'd8) $display("FAIL sat_level: got %0d expected 8", fifo_level); else pass_cnt++;
   endtask

   task automatic test_enable_reset();
      trace_enable = 1'b0; tr_ready = 1'b0;
      trace_pkt = mk_pkt(3'b111, 3'b000, 3'b000, 5'h0, 32'h0, 40); tick();
      total_cnt++; if (fifo_level !== 4'd8 || drop_count !== 4'd15) $display("FAIL en_full: got %0d %0d expected 8 15", fifo_level, drop_count); else pass_cnt++;
      tr_ready = 1'b1;
      tick(); tick(); tick();
      tr_ready = 1'b0;
      total_cnt++; if (fifo_level !== 4'd5) $display("FAIL en_drain: got %0d expected 5", fifo_level); else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++; if (tr_valid !== 1'b0 || idle !== 1'b1) $display("FAIL async_rst_flags: got valid %b idle %b expected 0 1", tr_valid, idle); else pass_cnt++;
      total_cnt++; if (fifo_level !== 4'd0 || drop_count !== 4'd0) $display("FAIL async_rst_counts: got %0d %0d expected 0 0", fifo_level, drop_count); else pass_cnt++;
      tick();
      rst = 1'b0; trace_pkt = '0;
      tick();
      total_cnt++; if (tr_valid !== 1'b0) $display("FAIL post_rst_valid: got %b expected 0", tr_valid); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_trap();
      test_overflow();
      test_back_to_back();
      test_saturation();
      test_enable_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
